// File: rtl/if_id_buffer_if.sv
// Handshake bundle between the fetch unit, the IF/ID buffer and the decode stage.
// slave  : the buffer's view (takes fetch inputs, drives decode outputs)
// master : the surrounding environment's view
interface if_id_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_inst;
  logic [WIDTH-1:0] in_pc;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_inst;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_pc_4;
  logic [4:0]       out_rs;
  logic [4:0]       out_rt;
  logic [4:0]       out_rd;
  logic [15:0]      out_imm16;
  logic             out_branch;
  logic             out_jump;

  modport slave (
    input  in_valid, in_inst, in_pc, flush, out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_pc_4,
           out_rs, out_rt, out_rd, out_imm16, out_branch, out_jump
  );

  modport master (
    output in_valid, in_inst, in_pc, flush, out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_pc_4,
           out_rs, out_rt, out_rd, out_imm16, out_branch, out_jump
  );
endinterface

// File: rtl/if_id_buffer.sv
// IF/ID stage: 2-entry skid buffer between fetch and decode with pre-decoded
// branch/jump flags and a flush that empties the buffer.
// Optional macro IFID_PERF_EN adds perf_accept / perf_flushed counters.
//
// state | meaning
// EMPTY | no entry held, out_valid=0
// ONE   | head holds the oldest entry
// TWO   | head and skid both hold entries, in_ready=0
module if_id_buffer #(
  parameter int         WIDTH  = 32,
  parameter logic [5:0] BEQ_OP = 6'h04,
  parameter logic [5:0] J_OP   = 6'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  if_id_buffer_if.slave     bus
`ifdef IFID_PERF_EN
  ,
  output logic [WIDTH-1:0]  perf_accept,
  output logic [WIDTH-1:0]  perf_flushed
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] head_inst_q, head_inst_d;
  logic [WIDTH-1:0] head_pc_q, head_pc_d;
  logic [WIDTH-1:0] skid_inst_q, skid_inst_d;
  logic [WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic             push;
  logic             pop;
  logic             in_ready;
  logic             out_valid;

  // Handshake qualifiers derived only from registered occupancy
  always_comb begin
    in_ready  = (state_q != TWO);
    out_valid = (state_q != EMPTY);
    push      = bus.in_valid & in_ready;
    pop       = out_valid & bus.out_ready;
  end

  // Next occupancy and storage; flush leaves payload untouched so outputs hold
  always_comb begin
    state_d     = state_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (bus.flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d     = ONE;
            head_inst_d = bus.in_inst;
            head_pc_d   = bus.in_pc;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state_d     = TWO;
            skid_inst_d = bus.in_inst;
            skid_pc_d   = bus.in_pc;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end else if (push && pop) begin
            head_inst_d = bus.in_inst;
            head_pc_d   = bus.in_pc;
          end
        end
        TWO: begin
          if (pop) begin
            state_d     = ONE;
            head_inst_d = skid_inst_q;
            head_pc_d   = skid_pc_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State and payload registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_inst_q <= '0;
      head_pc_q   <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = out_valid;
  assign bus.out_inst   = head_inst_q;
  assign bus.out_pc     = head_pc_q;
  assign bus.out_pc_4   = head_pc_q + WIDTH'(4);
  assign bus.out_rs     = head_inst_q[25:21];
  assign bus.out_rt     = head_inst_q[20:16];
  assign bus.out_rd     = head_inst_q[15:11];
  assign bus.out_imm16  = head_inst_q[15:0];
  assign bus.out_branch = out_valid & (head_inst_q[31:26] == BEQ_OP);
  assign bus.out_jump   = out_valid & (head_inst_q[31:26] == J_OP);

`ifdef IFID_PERF_EN
  logic [WIDTH-1:0] perf_accept_q, perf_accept_d;
  logic [WIDTH-1:0] perf_flushed_q, perf_flushed_d;
  logic [1:0]       occupancy;

  // Count accepted pushes and entries thrown away by each flush
  always_comb begin
    occupancy      = state_q;
    perf_accept_d  = perf_accept_q;
    perf_flushed_d = perf_flushed_q;
    if (push && !bus.flush) begin
      perf_accept_d = perf_accept_q + WIDTH'(1);
    end
    if (bus.flush) begin
      perf_flushed_d = perf_flushed_q + WIDTH'(occupancy) + WIDTH'(push) - WIDTH'(pop);
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_accept_q  <= '0;
      perf_flushed_q <= '0;
    end else begin
      perf_accept_q  <= perf_accept_d;
      perf_flushed_q <= perf_flushed_d;
    end
  end

  assign perf_accept  = perf_accept_q;
  assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: doc/if_id_buffer.md
Name: if_id_buffer

Overview:
- IF/ID stage sitting directly downstream of the instruction fetch unit.
- Captures {instruction, PC} pairs from fetch into a 2-entry skid buffer with a valid/ready handshake on both sides.
- Drives registered instruction fields plus pre-decoded Branch/Jump flags to the decode/control stage.
- Supports a flush from branch/jump resolution that discards every buffered entry.

Parameters:
- WIDTH, 32, instruction and PC width
- BEQ_OP, 6'h04, opcode decoded as branch
- J_OP, 6'h02, opcode decoded as jump

Ports:
- Clock  input  1  single system clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- in_valid  input  1  fetch presents a valid instruction
- in_ready  output  1  buffer can accept an instruction this cycle
- in_inst  input  WIDTH  instruction word from instruction memory
- in_pc  input  WIDTH  address the instruction was fetched from
- flush  input  1  discard all buffered and incoming entries
- out_valid  output  1  out_* payload is valid
- out_ready  input  1  decode stage consumes the entry this cycle
- out_inst  output  WIDTH  head instruction
- out_pc  output  WIDTH  head PC
- out_pc_4  output  WIDTH  out_pc + 4, modulo 2^WIDTH
- out_rs, out_rt, out_rd  output  5 each  inst[25:21], [20:16], [15:11]
- out_imm16  output  16  inst[15:0]
- out_branch  output  1  out_valid & (inst[31:26]==BEQ_OP)
- out_jump  output  1  out_valid & (inst[31:26]==J_OP)

Behaviour:
- Storage: head register and skid register, each holding {inst, pc, valid}. Occupancy state is EMPTY, ONE or TWO.
- Handshake events:
  - push = in_valid & in_ready
  - pop = out_valid & out_ready
- in_ready = (state != TWO). It depends only on registered state, never on out_ready.
- out_valid = (state != EMPTY). Output payload always comes from the head register.
- Transitions when flush=0:
  - EMPTY: push -> ONE, head <= input.
  - ONE, push & !pop -> TWO, skid <= input.
  - ONE, pop & !push -> EMPTY.
  - ONE, push & pop -> ONE, head <= input.
  - ONE, neither -> hold.
  - TWO, pop -> ONE, head <= skid. No push is possible in TWO because in_ready=0.
- Flush has the highest priority:
  - Next state is EMPTY.
  - A push in the same cycle is accepted (in_ready unaffected) and dropped.
  - A pop in the same cycle completes normally; the consumer owns that entry.
- Ordering: strict FIFO; no entry is duplicated or lost except by flush.
- Latency: one cycle from push to out_valid when EMPTY. Full throughput of one per cycle while out_ready=1.
- Output hold rules:
  - Payload is stable while out_valid=1 and out_ready=0.
  - When out_valid=0 the payload holds its last value.
  - out_branch and out_jump are forced to 0 when out_valid=0.
- out_pc_4 is computed combinationally from the head PC; it wraps at 0xFFFFFFFC -> 0x00000000.
- Reset (asynchronous assert, synchronous release by the Clock domain):
  - state = EMPTY.
  - Head and skid inst/pc = 0, so out_inst = 0 (NOP) and out_pc = 0.
  - out_valid = 0, in_ready = 1, out_branch = out_jump = 0.
- Reset mid-transfer discards all entries; nothing is replayed.

Optional Feature:
- Macro: IFID_PERF_EN.
- When defined, the block adds two outputs, reset to 0 by Reset:
  - perf_accept  WIDTH: increments on every push with flush=0.
  - perf_flushed  WIDTH: adds the number of entries discarded by each flush. This is the state occupancy plus 1 for a same-cycle push, minus 1 for a same-cycle pop.
- Both counters wrap modulo 2^WIDTH.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset release, push inst 0x08000004 at pc 0x0 -> next cycle out_valid=1, out_jump=1, out_pc_4=0x4, out_rs=0.
- Hold out_ready=0, push 3 consecutive -> first two accepted, in_ready=0 on the third; then out_ready=1 -> outputs appear in order pc 0x0, 0x4, 0x8 on consecutive cycles.
- Steady stream with out_ready=1 -> one instruction per cycle, state stays ONE, in_ready never drops.
- State TWO, flush=1 with pop=1 -> the popped entry is delivered, then out_valid=0 next cycle. With IFID_PERF_EN, perf_flushed increases by 1.
- Push beq 0x1022FFFF with flush=1 in the same cycle -> in_ready=1, entry dropped, out_valid stays 0.
- Assert Reset low mid-stream with state TWO -> immediately out_valid=0, in_ready=1, out_inst=0; after release the first output is the next fresh push.
